undet_issue_ctrl: RTL and testbench
===================================

# undet_issue_ctrl

Issue controller for the four-register undetermined-function datapath (`r0`..`r3`, driven by `en`/`ukn`). Accepts LOAD and STEP commands from two requesters, arbitrates, and sequences the datapath's `en` and `ukn` inputs. A LOAD injects `ukn` into `r1`; a STEP runs N consecutive enabled cycles. Each command is followed by a programmable settle window before the next grant. Sits directly in front of the datapath; all datapath control goes through this block.

## Interface
- `DW`, 8: data width of `ukn` and the command payload.
- `SETTLE`, 2: idle cycles after each command before the next grant; legal range 0..15.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req` in 2: per-requester request; held until granted.
- `req_op` in 2: per-requester opcode; 0 = LOAD, 1 = STEP.
- `req_data0` in DW: requester 0 payload. LOAD value, or STEP count.
- `req_data1` in DW: requester 1 payload.
- `gnt` out 2: one-hot, one-cycle grant pulse.
- `en` out 1: datapath enable.
- `ukn` out DW: datapath unknown-input value.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `done_id` out 1: requester index for `done`.

## Operation
- All outputs are registered.
- **Reset values:** `gnt` = 0, `en` = 0, `ukn` = 0, `busy` = 0, `done` = 0, `done_id` = 0. FSM = IDLE, arbiter favours requester 0.
- **FSM states:** IDLE, ISSUE, SETTLE.
- **IDLE:**
  - `en` = 0 and `ukn` holds the last driven value, so `r1` keeps a LOADed value.
  - If any `req` is high, capture the winner's op and data, and go to ISSUE.
- **ISSUE, LOAD:** one cycle with `en` = 0 and `ukn` = data.
- **ISSUE, STEP with count N (1..255):**
  - N consecutive cycles with `en` = 1; `ukn` is held.
  - A DW-bit down-counter tracks the remaining beats.
- **ISSUE, STEP with count 0:** one no-op cycle with `en` = 0; `ukn` is held.
- **SETTLE:**
  - Lasts exactly `SETTLE` cycles with `en` = 0; `ukn` is held.
  - When `SETTLE` = 0, go directly from ISSUE to IDLE.
- **Completion:** on the first IDLE cycle after a command, `done` = 1 and `done_id` = the owner.
  - A new request may be sampled in that same cycle.
- **Grant handshake:**
  - Requesters must keep `req`, `req_op` and `req_data*` stable until `gnt` is seen.
  - `req` is deasserted, or a new command presented, the cycle after `gnt`.
  - A `req` that drops before being granted is simply not served.
- **Simultaneous requests:** resolved by the arbiter (see Configuration). The loser stays pending.
- **Reset mid-operation:** all outputs go to reset values immediately. The captured command is discarded, no `done` is issued, and the arbiter pointer is cleared.

## Timing
- `req` sampled in IDLE at cycle k.
- `gnt` and the first ISSUE beat are at cycle k+1.
- LOAD: `done` at k+2+SETTLE.
- STEP N≥1: `en` high at cycles k+1..k+N; `done` at k+N+1+SETTLE.
- Back-to-back throughput is one command per 1+max(N,1)+SETTLE cycles.

## Configuration
- **`UNDET_ISSUE_RR_EN` defined:** round-robin arbitration. After a grant, the other requester has priority; ties are broken by a 1-bit last-grant pointer.
- **`UNDET_ISSUE_RR_EN` undefined:** fixed priority, requester 0 always wins. No pointer register exists.

## Structure
- **Package `undet_issue_pkg`:**
  - `op_e` {OP_LOAD = 0, OP_STEP = 1}.
  - `state_e` {IDLE, ISSUE, SETTLE}.
  - Defaults `DW_DEF` = 8 and `SETTLE_DEF` = 2.
- **Sub-module `undet_rr_arb`:** 2-way arbiter taking `req[1:0]` and an advance strobe, returning a one-hot grant. This is the only place `UNDET_ISSUE_RR_EN` is tested.
- **Top level:** FSM, payload capture, beat counter, settle counter, output registers.

## Test plan
- **LOAD:** `req[0]` with LOAD 0x5A at cycle 1 → cycle 2 `gnt` = 01, `en` = 0, `ukn` = 0x5A; `busy` high cycles 2..4; cycle 5 `done` = 1, `done_id` = 0; `ukn` stays 0x5A.
- **STEP:** `req[1]` with STEP 3 at cycle 1 → `en` = 1 at cycles 2..4, `en` = 0 at 5..6; `done` at 7 with `done_id` = 1.
- **Contention:** both requesting continuously, each with LOAD (0x11 / 0x22).
  - With macro: grants alternate 0, 1, 0.
  - Without macro: only `gnt[0]` ever pulses, every 4 cycles.
- **STEP 0 with `SETTLE` = 0:** `en` never rises; `done` 2 cycles after the sampling cycle; the next request is granted on the `done` cycle.
- **Reset mid-STEP:** STEP 10 is issued, and `rst` is pulled low during the 4th `en` beat → `en`, `busy` and `ukn` go to 0 asynchronously and no `done` is issued. After release, a pending `req[1]` is granted, with the pointer back at requester 0.

Source files
------------

// File: rtl/undet_issue_pkg.sv
// ----------------------------------------------------------------------------
// undet_issue_pkg
// Shared types and defaults for the undetermined-function datapath issue
// controller (undet_issue_ctrl) and its arbiter (undet_rr_arb).
//   op_e    : command opcode carried on req_op (LOAD / STEP)
//   state_e : issue controller FSM states
//   DW_DEF, SETTLE_DEF : default data width and settle window length
// ----------------------------------------------------------------------------
package undet_issue_pkg;

    localparam int DW_DEF     = 8;
    localparam int SETTLE_DEF = 2;

    typedef enum logic {
        OP_LOAD = 1'b0,
        OP_STEP = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_e;

endpackage

// File: rtl/undet_rr_arb.sv
// ----------------------------------------------------------------------------
// undet_rr_arb
// Two-way request arbiter for the issue controller.
// Build option UNDET_ISSUE_RR_EN:
//   defined   : round-robin; after a grant the other requester is favoured
//               on a tie, tracked by a 1-bit priority pointer.
//   undefined : fixed priority, requester 0 always wins; no state at all.
// Ports:
//   clk  in  : clock, rising edge
//   rst  in  : asynchronous active-low reset (clears the pointer)
//   req  in  : per-requester request
//   adv  in  : strobe, high when the current grant is actually taken
//   gnt  out : combinational one-hot grant (zero when no request)
// ----------------------------------------------------------------------------
module undet_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

`ifdef UNDET_ISSUE_RR_EN
    // prio_q = 0 favours requester 0, 1 favours requester 1
    logic prio_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prio_q ? 2'b10 : 2'b01;
        end
    end

    // After granting requester 0 favour requester 1, and vice versa
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q <= 1'b0;
        end else if (adv && (gnt != 2'b00)) begin
            prio_q <= gnt[0];
        end
    end
`else
    logic unused_arb;
    assign unused_arb = ^{clk, rst, adv};

    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/undet_issue_ctrl.sv
// ----------------------------------------------------------------------------
// undet_issue_ctrl
// Issue controller in front of the four-register undetermined-function
// datapath. Arbitrates LOAD / STEP commands from two requesters and drives
// the datapath en / ukn inputs. Every command is followed by a SETTLE-cycle
// quiet window before the next grant.
//   LOAD  : one cycle, en = 0, ukn = payload
//   STEP N: N consecutive en = 1 cycles (N = 0 gives a single no-op cycle)
// Build option UNDET_ISSUE_RR_EN selects round-robin arbitration (see
// undet_rr_arb); default build is fixed priority, requester 0 first.
// Parameters:
//   DW     : width of ukn and command payload
//   SETTLE : idle cycles after each command, 0..15
// Ports:
//   clk        in  : clock, rising edge
//   rst        in  : asynchronous active-low reset
//   req[1:0]   in  : per-requester request, held until granted
//   req_op[1:0]in  : per-requester opcode (0 LOAD, 1 STEP)
//   req_data0  in  : requester 0 payload (LOAD value or STEP count)
//   req_data1  in  : requester 1 payload
//   gnt[1:0]   out : one-hot one-cycle grant pulse
//   en         out : datapath enable
//   ukn        out : datapath unknown-input value
//   busy       out : high whenever the FSM is not IDLE
//   done       out : one-cycle completion pulse
//   done_id    out : requester that owned the completed command
// All outputs are registered.
// ----------------------------------------------------------------------------
module undet_issue_ctrl #(
    parameter int DW     = 8,
    parameter int SETTLE = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [1:0]    req_op,
    input  logic [DW-1:0] req_data0,
    input  logic [DW-1:0] req_data1,
    output logic [1:0]    gnt,
    output logic          en,
    output logic [DW-1:0] ukn,
    output logic          busy,
    output logic          done,
    output logic          done_id
);

    import undet_issue_pkg::*;

    // Reload value of the settle counter (counts down to zero inclusive)
    localparam int         SETTLE_M1   = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam logic [3:0] SETTLE_LAST = SETTLE_M1[3:0];

    state_e        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;        // remaining STEP beats after the current one
    logic [3:0]    scnt_q, scnt_d;      // remaining settle cycles after the current one
    logic          owner_q, owner_d;    // requester that owns the command in flight

    logic [1:0]    gnt_d;
    logic          en_d;
    logic [DW-1:0] ukn_d;
    logic          busy_d;
    logic          done_d;
    logic          done_id_d;

    logic [1:0]    arb_gnt;
    logic          arb_adv;
    op_e           sel_op;
    logic [DW-1:0] sel_data;

    undet_rr_arb u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .adv (arb_adv),
        .gnt (arb_gnt)
    );

    // Winner's command, only meaningful when arb_gnt is non-zero
    always_comb begin
        sel_op   = op_e'(req_op[arb_gnt[1]]);
        sel_data = arb_gnt[1] ? req_data1 : req_data0;
    end

    // Next-state and next-output logic; outputs are computed one cycle
    // ahead so that they can be registered
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scnt_d    = scnt_q;
        owner_d   = owner_q;
        gnt_d     = 2'b00;
        en_d      = 1'b0;
        ukn_d     = ukn;
        done_d    = 1'b0;
        done_id_d = done_id;
        arb_adv   = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    arb_adv = 1'b1;
                    gnt_d   = arb_gnt;
                    owner_d = arb_gnt[1];
                    state_d = ISSUE;
                    if (sel_op == OP_LOAD) begin
                        ukn_d = sel_data;
                        cnt_d = '0;
                    end else begin
                        // STEP 0 degenerates to one cycle with en low
                        en_d  = (sel_data != '0);
                        cnt_d = (sel_data != '0) ? sel_data - DW'(1) : '0;
                    end
                end
            end

            ISSUE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DW'(1);
                    en_d  = 1'b1;
                end else if (SETTLE == 0) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                end else begin
                    state_d = undet_issue_pkg::SETTLE;
                    scnt_d  = SETTLE_LAST;
                end
            end

            undet_issue_pkg::SETTLE: begin
                if (scnt_q != 4'd0) begin
                    scnt_d = scnt_q - 4'd1;
                end else begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset discards any command in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            scnt_q  <= 4'd0;
            owner_q <= 1'b0;
            gnt     <= 2'b00;
            en      <= 1'b0;
            ukn     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
            owner_q <= owner_d;
            gnt     <= gnt_d;
            en      <= en_d;
            ukn     <= ukn_d;
            busy    <= busy_d;
            done    <= done_d;
            done_id <= done_id_d;
        end
    end

endmodule

// File: tb/tb_undet_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_undet_issue_ctrl
// Bench for undet_issue_ctrl. Instance dut uses SETTLE = 2, instance dut0
// uses SETTLE = 0. Each test pushes the expected per-cycle output vector
// {gnt, en, ukn, busy, done, done_id} into a scoreboard queue as it drives
// the stimulus, then pops and compares one entry per clock.
// Honours UNDET_ISSUE_RR_EN for the contention expectations.
// ----------------------------------------------------------------------------
module tb_undet_issue_ctrl;

    typedef struct packed {
        logic [1:0] gnt;
        logic       en;
        logic [7:0] ukn;
        logic       busy;
        logic       done;
        logic       done_id;
    } exp_t;

    logic       clk;
    logic       rst;

    logic [1:0] a_req, a_op;
    logic [7:0] a_d0, a_d1;
    logic [1:0] a_gnt;
    logic       a_en, a_busy, a_done, a_done_id;
    logic [7:0] a_ukn;

    logic [1:0] b_req, b_op;
    logic [7:0] b_d0, b_d1;
    logic [1:0] b_gnt;
    logic       b_en, b_busy, b_done, b_done_id;
    logic [7:0] b_ukn;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    undet_issue_ctrl #(.DW(8), .SETTLE(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (a_req),
        .req_op    (a_op),
        .req_data0 (a_d0),
        .req_data1 (a_d1),
        .gnt       (a_gnt),
        .en        (a_en),
        .ukn       (a_ukn),
        .busy      (a_busy),
        .done      (a_done),
        .done_id   (a_done_id)
    );

    undet_issue_ctrl #(.DW(8), .SETTLE(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .req       (b_req),
        .req_op    (b_op),
        .req_data0 (b_d0),
        .req_data1 (b_d1),
        .gnt       (b_gnt),
        .en        (b_en),
        .ukn       (b_ukn),
        .busy      (b_busy),
        .done      (b_done),
        .done_id   (b_done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got no summary, required finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [1:0] g, input logic e, input logic [7:0] u,
                                input logic b, input logic d, input logic id);
        exp_t r;
        r.gnt     = g;
        r.en      = e;
        r.ukn     = u;
        r.busy    = b;
        r.done    = d;
        r.done_id = id;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t got;
        rst = 1'b0;
        a_req = 2'b00; a_op = 2'b00; a_d0 = 8'h00; a_d1 = 8'h00;
        b_req = 2'b00; b_op = 2'b00; b_d0 = 8'h00; b_d1 = 8'h00;
        repeat (3) tick();
        got = {a_gnt, a_en, a_ukn, a_busy, a_done, a_done_id};
        n_vec++;
        if (got !== exp_t'(0)) begin
            n_err++;
            $display("FAIL reset_a got=%h required=%h", got, exp_t'(0));
        end
        got = {b_gnt, b_en, b_ukn, b_busy, b_done, b_done_id};
        n_vec++;
        if (got !== exp_t'(0)) begin
            n_err++;
            $display("FAIL reset_b got=%h required=%h", got, exp_t'(0));
        end
        rst = 1'b1;
        tick();
        got = {a_gnt, a_en, a_ukn, a_busy, a_done, a_done_id};
        n_vec++;
        if (got !== exp_t'(0)) begin
            n_err++;
            $display("FAIL reset_idle got=%h required=%h", got, exp_t'(0));
        end
    endtask

    task automatic test_load;
        exp_t got, e;
        a_req = 2'b01; a_op = 2'b00; a_d0 = 8'h5A;
        sb.push_back(mk(2'b01, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(2'b00, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(2'b00, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(2'b00, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0));
        sb.push_back(mk(2'b00, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) a_req = 2'b00;
            got = {a_gnt, a_en, a_ukn, a_busy, a_done, a_done_id};
            e = sb.pop_front();
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL load cyc%0d got=%h required=%h", i + 1, got, e);
            end
        end
    endtask

    task automatic test_step;
        exp_t got, e;
        a_req = 2'b10; a_op = 2'b10; a_d1 = 8'd3;
        sb.push_back(mk(2'b10, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(2'b00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(2'b00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(2'b00, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(2'b00, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(2'b00, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1));
        sb.push_back(mk(2'b00, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) a_req = 2'b00;
            got = {a_gnt, a_en, a_ukn, a_busy, a_done, a_done_id};
            e = sb.pop_front();
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL step cyc%0d got=%h required=%h", i + 1, got, e);
            end
        end
    endtask

    task automatic test_contention;
        exp_t got, e;
        logic own [3];
        logic pid;
        logic [7:0] u;
`ifdef UNDET_ISSUE_RR_EN
        own[0] = 1'b0; own[1] = 1'b1; own[2] = 1'b0;
`else
        own[0] = 1'b0; own[1] = 1'b0; own[2] = 1'b0;
`endif
        a_req = 2'b11; a_op = 2'b00; a_d0 = 8'h11; a_d1 = 8'h22;
        for (int t = 1; t <= 12; t++) begin
            int j, ph;
            j   = (t - 1) / 4;
            ph  = (t - 1) % 4;
            u   = own[j] ? 8'h22 : 8'h11;
            pid = (j == 0) ? 1'b1 : own[j - 1];
            if (ph == 0)
                sb.push_back(mk(own[j] ? 2'b10 : 2'b01, 1'b0, u, 1'b1, 1'b0, pid));
            else if (ph == 3)
                sb.push_back(mk(2'b00, 1'b0, u, 1'b0, 1'b1, own[j]));
            else
                sb.push_back(mk(2'b00, 1'b0, u, 1'b1, 1'b0, pid));
        end
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 12) a_req = 2'b00;
            got = {a_gnt, a_en, a_ukn, a_busy, a_done, a_done_id};
            e = sb.pop_front();
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL contention cyc%0d got=%h required=%h", t, got, e);
            end
        end
    endtask

    task automatic test_step0_nosettle;
        exp_t got, e;
        b_req = 2'b11; b_op = 2'b01; b_d0 = 8'd0; b_d1 = 8'h3C;
        sb.push_back(mk(2'b01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
        sb.push_back(mk(2'b10, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(2'b00, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1));
        sb.push_back(mk(2'b00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) b_req = 2'b10;
            if (i == 2) b_req = 2'b00;
            got = {b_gnt, b_en, b_ukn, b_busy, b_done, b_done_id};
            e = sb.pop_front();
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL step0 cyc%0d got=%h required=%h", i + 1, got, e);
            end
        end
    endtask

    task automatic test_reset_mid_step;
        exp_t got, e;
        a_req = 2'b01; a_op = 2'b01; a_d0 = 8'd10;
        sb.push_back(mk(2'b01, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(2'b00, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(2'b00, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(2'b00, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) begin
                a_req = 2'b10; a_op = 2'b00; a_d1 = 8'h77;
            end
            got = {a_gnt, a_en, a_ukn, a_busy, a_done, a_done_id};
            e = sb.pop_front();
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL rststep cyc%0d got=%h required=%h", i + 1, got, e);
            end
        end
        // mid 4th beat, away from any edge
        #2;
        rst = 1'b0;
        #1;
        got = {a_gnt, a_en, a_ukn, a_busy, a_done, a_done_id};
        n_vec++;
        if (got !== exp_t'(0)) begin
            n_err++;
            $display("FAIL rst_async got=%h required=%h", got, exp_t'(0));
        end
        tick();
        got = {a_gnt, a_en, a_ukn, a_busy, a_done, a_done_id};
        n_vec++;
        if (got !== exp_t'(0)) begin
            n_err++;
            $display("FAIL rst_held got=%h required=%h", got, exp_t'(0));
        end
        rst = 1'b1;
        sb.push_back(mk(2'b10, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(2'b00, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(2'b00, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(2'b00, 1'b0, 8'h77, 1'b0, 1'b1, 1'b1));
        sb.push_back(mk(2'b00, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) a_req = 2'b00;
            got = {a_gnt, a_en, a_ukn, a_busy, a_done, a_done_id};
            e = sb.pop_front();
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL rst_after cyc%0d got=%h required=%h", i + 1, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_step();
        test_contention();
        test_step0_nosettle();
        test_reset_mid_step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
